train_step_sequencer: RTL
=========================

Name: train_step_sequencer

Overview:
- Hardware sequencer between the PS-facing GPIO control bits and the HLS kernels (forward, backward, gradient accumulate, parameter update).
- One software command runs a full training step without per-kernel GPIO polling: gradient-buffer reset, then N × (fw → bw → grad), then one param update.
- Drives kernel ap_start, consumes ap_done, reports busy/done/error status back to GPIO inputs.

Parameters:
BATCH_W, 16, width of cmd_batch and sample_cnt
TIMEOUT_CYCLES, 1048576, max cycles in any wait state before error; 0 disables timeout
TMO_W, 21, timeout counter width, must satisfy 2^TMO_W > TIMEOUT_CYCLES

Ports:
ap_clk  in  1  clock
ap_rst  in  1  synchronous active-high reset
cmd_start  in  1  level from GPIO; rising edge launches a step
cmd_batch  in  BATCH_W  samples per step, latched on the launch edge
fw_start  out  1  forward kernel ap_start
fw_done  in  1  forward kernel ap_done
bw_start  out  1  backward kernel ap_start
bw_done  in  1  backward kernel ap_done
grad_start  out  1  gradient-accumulate kernel ap_start
grad_done  in  1  gradient-accumulate ap_done
param_start  out  1  parameter-update kernel ap_start
param_done  in  1  parameter-update ap_done
grad_reset  out  1  gradient BRAM clear request, one-cycle pulse
grad_reset_busy  in  1  gradient clear in progress
busy  out  1  high in every state except IDLE, DONE, ERR
done  out  1  step completed, held until cmd_start low
err_timeout  out  1  wait-state timeout, held until cmd_start low
sample_cnt  out  BATCH_W  samples completed in the current/last step

Behaviour:
- Reset: all outputs 0, state IDLE, sample_cnt 0, latched batch 0, cmd_start edge register 0. Reset mid-step returns to IDLE next cycle with all starts low. In-flight kernels are not informed.
- Launch: cmd_start rising edge (registered prev = 0, current = 1) while in IDLE. A level already high out of reset does not launch. Edges outside IDLE are ignored.
- States and transitions:
  - IDLE: on launch, latch cmd_batch and clear sample_cnt. If batch == 0 → DONE. Otherwise → GRST.
  - GRST: grad_reset = 1 for exactly this one cycle → GRST_WAIT.
  - GRST_WAIT: stay at least 2 cycles, then leave when grad_reset_busy == 0 → FW.
  - FW / BW / GRAD / PARAM: the matching *_start is 1 from the entry cycle through the cycle its *_done is sampled 1; it is 0 the following cycle. Exactly one start is high at a time.
  - FW done → BW. BW done → GRAD.
  - GRAD done: sample_cnt += 1. If the new sample_cnt == batch → PARAM, else → FW.
  - PARAM done → DONE.
  - DONE: done = 1. When cmd_start == 0 → IDLE, done cleared.
  - ERR: err_timeout = 1, all starts 0. When cmd_start == 0 → IDLE.
- A done input is sampled only in its own state. Stray or early done pulses in other states are ignored.
- Latency: minimum 1 cycle from *_done to the next kernel's start. A done in the entry cycle is legal.
- Timeout: counter clears on every state entry and increments each cycle in GRST_WAIT, FW, BW, GRAD, PARAM. If it reaches TIMEOUT_CYCLES−1 without the exit condition → ERR next cycle. A done arriving on that same cycle wins (normal transition). TIMEOUT_CYCLES = 0 disables the check.
- sample_cnt is held after DONE/ERR until the next launch. The comparison with batch is full-width unsigned; batch = 2^BATCH_W−1 is legal.
- cmd_batch changes after launch have no effect.

Test Plan:
- Basic step, batch = 2, each done 3 cycles after its start, busy 0 → start sequence fw, bw, grad, fw, bw, grad, param.
  - grad_reset is a single pulse, first fw_start is no earlier than GRST entry + 3.
  - done = 1, sample_cnt = 2, busy = 0.
  - Drop cmd_start → done = 0, IDLE.
- Back-to-back done: every done asserted in the start's entry cycle → each start high exactly 1 cycle. Batch = 1 totals 4 start pulses, no overlap.
- Batch = 0 → no starts and no grad_reset. done = 1 two cycles after the edge, sample_cnt = 0.
- Timeout, TIMEOUT_CYCLES = 16, bw_done never asserts → bw_start high 16 cycles, then err_timeout = 1 and all starts 0. Clear with cmd_start low, relaunch completes normally.
- grad_reset_busy held 1 for 10 cycles → fw_start does not rise until the cycle after busy falls. A stray fw_done during GRST_WAIT is ignored.
- ap_rst asserted during GRAD of sample 1 (batch = 4) → next cycle all outputs 0, IDLE. cmd_start held high through reset does not relaunch; a low→high edge does, with sample_cnt restarting at 0.

Source files
------------

// File: rtl/train_step_sequencer.sv
// train_step_sequencer: runs grad reset, N x (fw, bw, grad), then param update per software command
module train_step_sequencer #(
    parameter int BATCH_W        = 16,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int TMO_W          = 21
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic               cmd_start,
    input  logic [BATCH_W-1:0] cmd_batch,
    output logic               fw_start,
    input  logic               fw_done,
    output logic               bw_start,
    input  logic               bw_done,
    output logic               grad_start,
    input  logic               grad_done,
    output logic               param_start,
    input  logic               param_done,
    output logic               grad_reset,
    input  logic               grad_reset_busy,
    output logic               busy,
    output logic               done,
    output logic               err_timeout,
    output logic [BATCH_W-1:0] sample_cnt
);
    typedef enum logic [3:0] {IDLE, GRST, GRST_WAIT, FW, BW, GRAD, PARAM, DONE, ERR} state_t;
    state_t state, state_nxt, follow;
    logic cmd_prev, armed, grst_seen, launch, waiting, tmo_hit, adv;
    logic [BATCH_W-1:0] batch, sample_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    // armed blocks a level that was already high when reset released from counting as an edge
    assign launch      = cmd_start && !cmd_prev && armed;
    assign sample_nxt  = sample_cnt + BATCH_W'(1);
    assign waiting     = state inside {GRST_WAIT, FW, BW, GRAD, PARAM};
    assign tmo_hit     = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign fw_start    = state == FW;
    assign bw_start    = state == BW;
    assign grad_start  = state == GRAD;
    assign param_start = state == PARAM;
    assign grad_reset  = state == GRST;
    assign done        = state == DONE;
    assign err_timeout = state == ERR;
    assign busy        = !(state inside {IDLE, DONE, ERR});
    // next state: a wait state's exit condition beats a simultaneous timeout
    always_comb begin
        adv       = 1'b0;
        follow    = state;
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = launch ? ((cmd_batch == '0) ? DONE : GRST) : IDLE;
            GRST:      state_nxt = GRST_WAIT;
            GRST_WAIT: begin adv = grst_seen && !grad_reset_busy; follow = FW; end
            FW:        begin adv = fw_done; follow = BW; end
            BW:        begin adv = bw_done; follow = GRAD; end
            GRAD:      begin adv = grad_done; follow = (sample_nxt == batch) ? PARAM : FW; end
            PARAM:     begin adv = param_done; follow = DONE; end
            DONE, ERR: state_nxt = cmd_start ? state : IDLE;
            default:   state_nxt = IDLE;
        endcase
        if (waiting)
            state_nxt = adv ? follow : (tmo_hit ? ERR : state);
    end
    // state, edge detect, batch latch, sample count and wait timer
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state      <= IDLE;
            cmd_prev   <= 1'b0;
            armed      <= !cmd_start;
            batch      <= '0;
            sample_cnt <= '0;
            tmo_cnt    <= '0;
            grst_seen  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cmd_prev  <= cmd_start;
            armed     <= armed || !cmd_start;
            grst_seen <= (state == GRST_WAIT) && (state_nxt == GRST_WAIT);
            tmo_cnt   <= (!waiting || state_nxt != state) ? '0 : tmo_cnt + TMO_W'(1);
            if (state == IDLE && launch) begin
                batch      <= cmd_batch;
                sample_cnt <= '0;
            end else if (state == GRAD && grad_done) begin
                sample_cnt <= sample_nxt;
            end
        end
    end
endmodule
